fwrisc_exec_seq: RTL

//  Execute-stage sequencer for the fwrisc core. Accepts one decoded instruction at a time.

---
 rtl/fwrisc_exec_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fwrisc_exec_seq.sv
// fwrisc execute-stage sequencer: drives the shared ALU, runs the
// load/store bus handshake, writes the register file and retires instructions.
module fwrisc_exec_seq #(
   parameter bit ALIGN_CHECK = 1'b1,
   parameter int INSTR_CNT_W = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   decode_valid,
   output logic                   decode_ready,
   input  logic [4:0]             op_type,
   input  logic [5:0]             op,
   input  logic [31:0]            op_a,
   input  logic [31:0]            op_b,
   input  logic [31:0]            op_c,
   input  logic [5:0]             rd,
   output logic [5:0]             alu_op,
   output logic [31:0]            alu_op_a,
   output logic [31:0]            alu_op_b,
   input  logic [31:0]            alu_out,
   output logic [5:0]             rd_waddr,
   output logic [31:0]            rd_wdata,
   output logic                   rd_wen,
   output logic [31:0]            daddr,
   output logic                   dvalid,
   output logic                   dwrite,
   output logic [31:0]            dwdata,
   output logic [3:0]             dwstb,
   input  logic [31:0]            drdata,
   input  logic                   dready,
   output logic                   instr_complete,
   output logic                   misalign,
   output logic [INSTR_CNT_W-1:0] instr_count
);

   localparam logic [4:0] OP_TYPE_LDST = 5'd1;
   localparam logic [5:0] OP_ADD       = 6'd0;

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MEM, S_WB, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic                   ldst_q, ldst_d;
   logic [5:0]             op_q, op_d;
   logic [31:0]            a_q, a_d;
   logic [31:0]            b_q, b_d;
   logic [31:0]            c_q, c_d;
   logic [5:0]             rd_q, rd_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            ldata_q, ldata_d;
   logic                   mis_q, mis_d;
   logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]  size;
   logic        ea_mis;
   logic [31:0] ea_al;
   logic [31:0] ld_sh;
   logic [31:0] ld_ext;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ldst_q  <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         rd_q    <= '0;
         addr_q  <= '0;
         ldata_q <= '0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ldst_q  <= ldst_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         ldata_q <= ldata_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   // Size 3 falls into the word cases everywhere via size[1]
   always_comb begin
      size   = op_q[1:0];
      ea_mis = ((size == 2'd1) && alu_out[0]) ||
               (size[1] && (alu_out[1:0] != 2'b00));
      ea_al  = alu_out;
      if (!ALIGN_CHECK) begin
         if (size == 2'd1) ea_al[0] = 1'b0;
         else if (size[1]) ea_al[1:0] = 2'b00;
      end
      ld_sh = ldata_q >> {addr_q[1:0], 3'b000};
      case (size)
         2'd0:    ld_ext = {{24{~op_q[2] & ld_sh[7]}}, ld_sh[7:0]};
         2'd1:    ld_ext = {{16{~op_q[2] & ld_sh[15]}}, ld_sh[15:0]};
         default: ld_ext = ld_sh;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ldst_d  = ldst_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      ldata_d = ldata_q;
      mis_d   = mis_q;
      cnt_d   = cnt_q;

      decode_ready   = 1'b0;
      alu_op         = '0;
      alu_op_a       = '0;
      alu_op_b       = '0;
      rd_waddr       = '0;
      rd_wdata       = '0;
      rd_wen         = 1'b0;
      daddr          = '0;
      dvalid         = 1'b0;
      dwrite         = 1'b0;
      dwdata         = '0;
      dwstb          = '0;
      instr_complete = 1'b0;
      misalign       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            decode_ready = 1'b1;
            if (decode_valid) begin
               ldst_d  = (op_type == OP_TYPE_LDST);
               op_d    = op;
               a_d     = op_a;
               b_d     = op_b;
               c_d     = op_c;
               rd_d    = rd;
               mis_d   = 1'b0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (ldst_q) begin
               alu_op   = OP_ADD;
               alu_op_a = a_q;
               alu_op_b = c_q;
               addr_d   = ea_al;
               if (ALIGN_CHECK && ea_mis) begin
                  mis_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_MEM;
               end
            end else begin
               alu_op   = op_q;
               alu_op_a = a_q;
               alu_op_b = b_q;
               rd_wen   = 1'b1;
               rd_waddr = rd_q;
               rd_wdata = alu_out;
               state_d  = S_DONE;
            end
         end
         S_MEM: begin
            dvalid = 1'b1;
            daddr  = {addr_q[31:2], 2'b00};
            dwrite = op_q[3];
            case (size)
               2'd0: begin
                  dwdata = {4{b_q[7:0]}};
                  dwstb  = 4'b0001 << addr_q[1:0];
               end
               2'd1: begin
                  dwdata = {2{b_q[15:0]}};
                  dwstb  = 4'b0011 << {addr_q[1], 1'b0};
               end
               default: begin
                  dwdata = b_q;
                  dwstb  = 4'b1111;
               end
            endcase
            if (dready) begin
               ldata_d = drdata;
               state_d = op_q[3] ? S_DONE : S_WB;
            end
         end
         S_WB: begin
            rd_wen   = 1'b1;
            rd_waddr = rd_q;
            rd_wdata = ld_ext;
            state_d  = S_DONE;
         end
         S_DONE: begin
            instr_complete = 1'b1;
            misalign       = mis_q;
            cnt_d          = cnt_q + INSTR_CNT_W'(1);
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign instr_count = cnt_q;

endmodule
